// File: rtl/cdcfifo_wr_seq_pkg.sv
// Shared LVDS RX definitions for the CDC FIFO write-side sequencer.
// State encoding and default tuning constants live here.
package cdcfifo_wr_seq_pkg;

  localparam int DEF_HEADROOM  = 4;
  localparam int DEF_FLUSH_CYC = 8;
  localparam int DEF_LWM       = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WAIT_SOF,
    ST_RUN,
    ST_RECOVER
  } wr_state_e;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cdcfifo_wr_seq.sv
// CDC FIFO write-side sequencer: flush, frame lock-on,
// overflow drop and watermark-gated recovery on wrclk.
module cdcfifo_wr_seq
  import cdcfifo_wr_seq_pkg::*;
#(
  parameter int DATA_W    = 74,
  parameter int ADDR_W    = 4,
  parameter int HEADROOM  = DEF_HEADROOM,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC,
  parameter int LWM       = DEF_LWM
) (
  input  logic              wrclk,
  input  logic              wrrstn,
  input  logic              pll_lock,
  input  logic              align_done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              fifo_wrfull,
  input  logic [ADDR_W-1:0] fifo_wrusedw,
  output logic              fifo_wrreq,
  output logic [DATA_W-1:0] fifo_wrdata,
  output logic              fifo_wrsrst,
  output logic [ADDR_W-1:0] fifo_k_lim,
  output logic              running,
  output logic              ovf_pulse,
  output logic [15:0]       ovf_count
);

  localparam int KLIM = (1 << ADDR_W) - HEADROOM;
  localparam int FCW  = $clog2(FLUSH_CYC + 1);
  localparam logic [FCW-1:0] FLAST =
    FCW'(FLUSH_CYC - 1);
  localparam logic [ADDR_W:0] LWM_V =
    (ADDR_W + 1)'(LWM);

  wr_state_e r_state;
  wr_state_e w_state_nxt;

  logic [FCW-1:0]    r_flush_cnt;
  logic [FCW-1:0]    w_flush_cnt_nxt;
  logic              r_lwm_seen;
  logic              w_lwm_seen_nxt;
  logic              r_wrreq;
  logic [DATA_W-1:0] r_wrdata;
  logic              r_ovf_pulse;
  logic [15:0]       r_ovf_count;

  logic w_lock;
  logic w_low;
  logic w_wr;
  logic w_drop;

  assign w_lock = pll_lock & align_done;
  assign w_low  = ({1'b0, fifo_wrusedw} <= LWM_V);

  // Next state, flush timing and write/drop decisions.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_lwm_seen_nxt  = r_lwm_seen;
    w_wr            = 1'b0;
    w_drop          = 1'b0;
    if (r_state != ST_IDLE && !w_lock) begin
      w_state_nxt     = ST_IDLE;
      w_flush_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_flush_cnt_nxt = '0;
          if (w_lock) w_state_nxt = ST_FLUSH;
        end
        ST_FLUSH: begin
          if (r_flush_cnt == FLAST) begin
            w_state_nxt     = ST_WAIT_SOF;
            w_flush_cnt_nxt = '0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt + 1'b1;
          end
        end
        ST_WAIT_SOF: begin
          if (in_valid && in_sof) begin
            w_wr        = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            if (!fifo_wrfull) begin
              w_wr = 1'b1;
            end else begin
              w_drop         = 1'b1;
              w_state_nxt    = ST_RECOVER;
              w_lwm_seen_nxt = 1'b0;
            end
          end
        end
        ST_RECOVER: begin
          if (w_low) w_lwm_seen_nxt = 1'b1;
          if ((r_lwm_seen || w_low) &&
              in_valid && in_sof) begin
            w_wr        = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_flush_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Sequencer state, flush counter and watermark latch.
  always_ff @(posedge wrclk or negedge wrrstn) begin
    if (!wrrstn) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
      r_lwm_seen  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_lwm_seen  <= w_lwm_seen_nxt;
    end
  end

  // Registered write port; data holds between writes.
  always_ff @(posedge wrclk or negedge wrrstn) begin
    if (!wrrstn) begin
      r_wrreq  <= 1'b0;
      r_wrdata <= '0;
    end else begin
      r_wrreq <= w_wr;
      if (w_wr) r_wrdata <= in_data;
    end
  end

  // Overflow pulse and saturating drop counter.
  always_ff @(posedge wrclk or negedge wrrstn) begin
    if (!wrrstn) begin
      r_ovf_pulse <= 1'b0;
      r_ovf_count <= '0;
    end else begin
      r_ovf_pulse <= w_drop;
      if (w_drop) r_ovf_count <= sat_inc16(r_ovf_count);
    end
  end

  assign fifo_wrreq  = r_wrreq;
  assign fifo_wrdata = r_wrdata;
  assign fifo_wrsrst = (r_state == ST_FLUSH);
  assign running     = (r_state == ST_RUN);
  assign ovf_pulse   = r_ovf_pulse;
  assign ovf_count   = r_ovf_count;
  assign fifo_k_lim  = ADDR_W'(KLIM);

endmodule

// File: tb/tb_cdcfifo_wr_seq.sv
// Self-checking bench for cdcfifo_wr_seq: directed steps
// plus random traffic against a phase-level reference model.
module tb_cdcfifo_wr_seq;

  localparam int DW  = 74;
  localparam int AW  = 4;
  localparam int FC  = 8;
  localparam int LW  = 2;
  localparam int KL  = (1 << AW) - 4;

  localparam int P_IDLE = 0;
  localparam int P_FL   = 1;
  localparam int P_WAIT = 2;
  localparam int P_RUN  = 3;
  localparam int P_REC  = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          pll_lock;
  logic          align_done;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          wrfull;
  logic [AW-1:0] usedw;
  logic          wrreq;
  logic [DW-1:0] wrdata;
  logic          wrsrst;
  logic [AW-1:0] klim;
  logic          running;
  logic          ovf_pulse;
  logic [15:0]   ovf_count;

  int n_assert = 0;
  int n_fail   = 0;

  int            ph;
  int            fl;
  bit            seen;
  logic          m_wrreq;
  logic [DW-1:0] m_wrdata;
  logic          m_pulse;
  int            m_cnt;

  int obs_wr;
  int obs_srst;
  int obs_pulse;

  always #5 clk = ~clk;

  cdcfifo_wr_seq dut (
    .wrclk        (clk),
    .wrrstn       (rstn),
    .pll_lock     (pll_lock),
    .align_done   (align_done),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_sof       (in_sof),
    .fifo_wrfull  (wrfull),
    .fifo_wrusedw (usedw),
    .fifo_wrreq   (wrreq),
    .fifo_wrdata  (wrdata),
    .fifo_wrsrst  (wrsrst),
    .fifo_k_lim   (klim),
    .running      (running),
    .ovf_pulse    (ovf_pulse),
    .ovf_count    (ovf_count)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    ph       = P_IDLE;
    fl       = 0;
    seen     = 1'b0;
    m_wrreq  = 1'b0;
    m_wrdata = '0;
    m_pulse  = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic check_all();
    chk("wrreq", wrreq, m_wrreq);
    chk("wrdata", wrdata, m_wrdata);
    chk("wrsrst", wrsrst, (ph == P_FL));
    chk("running", running, (ph == P_RUN));
    chk("ovf_pulse", ovf_pulse, m_pulse);
    chk("ovf_count", ovf_count, m_cnt[15:0]);
    chk("k_lim", klim, KL[AW-1:0]);
    chk("excl", wrreq & wrsrst, 1'b0);
  endtask

  // One wrclk cycle: predict from driven inputs, clock, compare.
  task automatic step();
    bit lk;
    bit wr;
    bit drop;
    int nph;
    lk   = pll_lock && align_done;
    wr   = 1'b0;
    drop = 1'b0;
    nph  = ph;
    if (ph != P_IDLE && !lk) begin
      nph = P_IDLE;
    end else begin
      case (ph)
        P_IDLE: if (lk) begin
          nph = P_FL;
          fl  = 0;
        end
        P_FL: begin
          fl++;
          if (fl == FC) nph = P_WAIT;
        end
        P_WAIT: if (in_valid && in_sof) begin
          wr  = 1'b1;
          nph = P_RUN;
        end
        P_RUN: if (in_valid) begin
          if (!wrfull) wr = 1'b1;
          else begin
            drop = 1'b1;
            nph  = P_REC;
            seen = 1'b0;
          end
        end
        P_REC: begin
          if (int'(usedw) <= LW) seen = 1'b1;
          if (seen && in_valid && in_sof) begin
            wr  = 1'b1;
            nph = P_RUN;
          end
        end
        default: nph = P_IDLE;
      endcase
    end
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      ph      = nph;
      m_wrreq = wr;
      if (wr) m_wrdata = in_data;
      m_pulse = drop;
      if (drop && m_cnt < 65535) m_cnt++;
    end
    #1;
    if (wrreq === 1'b1) obs_wr++;
    if (wrsrst === 1'b1) obs_srst++;
    if (ovf_pulse === 1'b1) obs_pulse++;
    check_all();
  endtask

  task automatic drive(input logic v, input logic s,
                       input logic f, input int u);
    in_valid = v;
    in_sof   = s;
    wrfull   = f;
    usedw    = u[AW-1:0];
    in_data  = rnd_word();
  endtask

  initial begin
    logic [DW-1:0] d;
    rstn       = 1'b0;
    pll_lock   = 1'b0;
    align_done = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0);
    model_reset();
    obs_wr = 0; obs_srst = 0; obs_pulse = 0;

    // Reset state.
    step();
    step();

    // Release with lock held: 8-cycle flush, no write before sof.
    rstn       = 1'b1;
    pll_lock   = 1'b1;
    align_done = 1'b1;
    obs_wr = 0; obs_srst = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b0, 0);
      step();
    end
    chk("flush_len", obs_srst, 8);
    chk("no_wr_before_sof", obs_wr, 0);

    // 20-word frame, no backpressure.
    obs_wr = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i == 0), 1'b0, 3);
      d = in_data;
      step();
      chk("frame_req", wrreq, 1'b1);
      chk("frame_data", wrdata, d);
    end
    chk("frame_count", obs_wr, 20);
    chk("frame_running", running, 1'b1);

    // Single-cycle full during RUN, then watermark recovery.
    obs_pulse = 0;
    drive(1'b1, 1'b0, 1'b1, 15);
    step();
    chk("ovf_cnt1", ovf_count, 16'd1);
    chk("ovf_rec", running, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 9);
    step();
    chk("rec_hold", wrreq, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1);
    step();
    drive(1'b1, 1'b1, 1'b0, 9);
    d = in_data;
    step();
    chk("rec_resume_req", wrreq, 1'b1);
    chk("rec_resume_data", wrdata, d);
    chk("ovf_pulses", obs_pulse, 1);

    // Lock loss mid-frame, then full reflush before writing.
    drive(1'b1, 1'b0, 1'b0, 4);
    step();
    pll_lock = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4);
    step();
    chk("unlock_req", wrreq, 1'b0);
    chk("unlock_run", running, 1'b0);
    step();
    pll_lock = 1'b1;
    obs_wr = 0; obs_srst = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b0, 0);
      step();
    end
    chk("relock_flush", obs_srst, 8);
    chk("relock_nowr", obs_wr, 0);
    drive(1'b1, 1'b1, 1'b0, 0);
    step();
    chk("relock_wr", wrreq, 1'b1);

    // Counter preset near the top, then overflows past it.
    drive(1'b0, 1'b0, 1'b0, 0);
    force dut.r_ovf_count = 16'hFFFD;
    #1;
    release dut.r_ovf_count;
    m_cnt = 65533;
    obs_pulse = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 15);
      step();
      chk("sat_pulse", ovf_pulse, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 0);
      step();
    end
    chk("sat_value", ovf_count, 16'hFFFF);
    chk("sat_pulses", obs_pulse, 3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      pll_lock   = ($urandom_range(0, 99) != 0);
      align_done = ($urandom_range(0, 149) != 0);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 14) == 0,
            $urandom_range(0, 15));
      step();
    end

    // Asynchronous reset mid-frame.
    pll_lock   = 1'b1;
    align_done = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, (i == 10), 1'b0, 0);
      step();
    end
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all();
    step();
    rstn = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 0);
    step();
    chk("post_rst_flush", wrsrst, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
